// File: rtl/seg7_pkg.sv
// Segment encodings and output bit positions shared by the seven-segment scan controller.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  // Segment patterns are {a,b,c,d,e,f,g}; a '1' lights the segment.
  localparam seg_t SEG_HEX_0 = 7'b1111110;
  localparam seg_t SEG_HEX_1 = 7'b0110000;
  localparam seg_t SEG_HEX_2 = 7'b1101101;
  localparam seg_t SEG_HEX_3 = 7'b1111001;
  localparam seg_t SEG_HEX_4 = 7'b0110011;
  localparam seg_t SEG_HEX_5 = 7'b1011011;
  localparam seg_t SEG_HEX_6 = 7'b1011111;
  localparam seg_t SEG_HEX_7 = 7'b1110000;
  localparam seg_t SEG_HEX_8 = 7'b1111111;
  localparam seg_t SEG_HEX_9 = 7'b1111011;
  localparam seg_t SEG_HEX_A = 7'b1110111;
  localparam seg_t SEG_HEX_B = 7'b0011111;
  localparam seg_t SEG_HEX_C = 7'b1001110;
  localparam seg_t SEG_HEX_D = 7'b0111101;
  localparam seg_t SEG_HEX_E = 7'b1001111;
  localparam seg_t SEG_HEX_F = 7'b1000111;

  localparam int SEG_A_POS  = 7;
  localparam int SEG_B_POS  = 6;
  localparam int SEG_C_POS  = 5;
  localparam int SEG_D_POS  = 4;
  localparam int SEG_E_POS  = 3;
  localparam int SEG_F_POS  = 2;
  localparam int SEG_G_POS  = 1;
  localparam int SEG_DP_POS = 0;

  // Wide enough for the largest digit count; callers slice to their width.
  localparam logic [15:0] COM_OFF = 16'hFFFF;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment pattern decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hexNibble,
  output seg_t       segments
);

  always_comb begin
    segments = SEG_HEX_0;
    case (hexNibble)
      4'h0: segments = SEG_HEX_0;
      4'h1: segments = SEG_HEX_1;
      4'h2: segments = SEG_HEX_2;
      4'h3: segments = SEG_HEX_3;
      4'h4: segments = SEG_HEX_4;
      4'h5: segments = SEG_HEX_5;
      4'h6: segments = SEG_HEX_6;
      4'h7: segments = SEG_HEX_7;
      4'h8: segments = SEG_HEX_8;
      4'h9: segments = SEG_HEX_9;
      4'hA: segments = SEG_HEX_A;
      4'hB: segments = SEG_HEX_B;
      4'hC: segments = SEG_HEX_C;
      4'hD: segments = SEG_HEX_D;
      4'hE: segments = SEG_HEX_E;
      4'hF: segments = SEG_HEX_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered display data,
// leading-zero suppression, per-digit blanking and PWM brightness.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_W     = 10,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    iCLK,
  input  logic                    nRST,
  input  logic [4*NUM_DIGITS-1:0] iDATA,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic [NUM_DIGITS-1:0]   iBLANK,
  input  logic [BRIGHT_W-1:0]     iBRIGHT,
  input  logic                    iLZS,
  input  logic                    iLOAD,
  output logic [NUM_DIGITS-1:0]   oS_COM,
  output logic [7:0]              oS_ENS,
  output logic                    oFRAME
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]       prescaler;
  logic [IDX_W-1:0]        digitIdx;
  logic                    slotEnd;
  logic                    frameEnd;

  logic [4*NUM_DIGITS-1:0] pendData, actData;
  logic [NUM_DIGITS-1:0]   pendDp, actDp;
  logic [NUM_DIGITS-1:0]   pendBlank, actBlank;
  logic [BRIGHT_W-1:0]     pendBright, actBright;
  logic                    pendLzs, actLzs;

  logic [NUM_DIGITS-1:0]   zeroFrom;
  logic [3:0]              curNibble;
  seg_t                    curSegs;
  logic                    suppress;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   comNext;
  logic [7:0]              ensNext;

  assign slotEnd  = (prescaler == '1);
  assign frameEnd = slotEnd && (digitIdx == LAST_IDX);

  always_ff @(posedge iCLK) begin
    if (nRST) begin
      prescaler <= '0;
      digitIdx  <= '0;
      oFRAME    <= 1'b0;
    end else begin
      prescaler <= prescaler + SCAN_W'(1);
      if (slotEnd)
        digitIdx <= frameEnd ? '0 : digitIdx + IDX_W'(1);
      oFRAME <= frameEnd;
    end
  end

  // Active copies only change at the frame boundary so a frame never mixes old and new data.
  always_ff @(posedge iCLK) begin
    if (nRST) begin
      pendData   <= '0;
      pendDp     <= '0;
      pendBlank  <= '1;
      pendBright <= '0;
      pendLzs    <= 1'b0;
      actData    <= '0;
      actDp      <= '0;
      actBlank   <= '1;
      actBright  <= '0;
      actLzs     <= 1'b0;
    end else begin
      if (iLOAD) begin
        pendData   <= iDATA;
        pendDp     <= iDP;
        pendBlank  <= iBLANK;
        pendBright <= iBRIGHT;
        pendLzs    <= iLZS;
      end
      if (frameEnd) begin
        actData   <= pendData;
        actDp     <= pendDp;
        actBlank  <= pendBlank;
        actBright <= pendBright;
        actLzs    <= pendLzs;
      end
    end
  end

  // zeroFrom[k] is set when nibble k and every nibble above it are zero.
  always_comb begin
    zeroFrom = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      zeroFrom[k] = ((actData >> (4 * k)) == '0);
  end

  assign curNibble = actData[{digitIdx, 2'b00} +: 4];

  seg7_hex_decode uDecode (
    .hexNibble (curNibble),
    .segments  (curSegs)
  );

  assign suppress = actLzs && (digitIdx != '0) && zeroFrom[digitIdx];
  assign lit      = !actBlank[digitIdx]
                    && (prescaler[SCAN_W-1 -: BRIGHT_W] < actBright);

  always_comb begin
    comNext = COM_OFF[NUM_DIGITS-1:0];
    ensNext = '0;
    if (lit) begin
      comNext = ~(NUM_DIGITS'(1) << digitIdx);
      ensNext[SEG_A_POS -: 7] = suppress ? 7'b0 : curSegs;
      ensNext[SEG_DP_POS]     = actDp[digitIdx];
    end
  end

  always_ff @(posedge iCLK) begin
    if (nRST) begin
      oS_COM <= COM_OFF[NUM_DIGITS-1:0];
      oS_ENS <= '0;
    end else begin
      oS_COM <= comNext;
      oS_ENS <= ensNext;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl with 4 digits, 16-clock slots, 2-bit brightness.
module tb_seg7_scan_ctrl;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [1:0]  bright;
    logic        lzs;
  } cfg_t;

  localparam cfg_t CFG_NONE   = '{data:16'h0000, dp:4'h0, blank:4'hF, bright:2'd0, lzs:1'b0};
  localparam cfg_t CFG_1234   = '{data:16'h1234, dp:4'h0, blank:4'h0, bright:2'd3, lzs:1'b0};
  localparam cfg_t CFG_ABCD   = '{data:16'hABCD, dp:4'h0, blank:4'h0, bright:2'd3, lzs:1'b0};
  localparam cfg_t CFG_0F00   = '{data:16'h0F00, dp:4'h0, blank:4'h0, bright:2'd3, lzs:1'b0};
  localparam cfg_t CFG_LZ0    = '{data:16'h0000, dp:4'b1001, blank:4'h0, bright:2'd3, lzs:1'b1};
  localparam cfg_t CFG_LZ100  = '{data:16'h0100, dp:4'h0, blank:4'h0, bright:2'd3, lzs:1'b1};
  localparam cfg_t CFG_BLANK0 = '{data:16'h1234, dp:4'b0010, blank:4'b0010, bright:2'd0, lzs:1'b0};
  localparam cfg_t CFG_BLANK1 = '{data:16'h1234, dp:4'b0010, blank:4'b0010, bright:2'd1, lzs:1'b0};
  localparam cfg_t CFG_5678   = '{data:16'h5678, dp:4'h0, blank:4'h0, bright:2'd3, lzs:1'b0};
  localparam cfg_t CFG_9ABC   = '{data:16'h9ABC, dp:4'b0100, blank:4'h0, bright:2'd2, lzs:1'b0};

  logic        iCLK;
  logic        nRST;
  logic [15:0] iDATA;
  logic [3:0]  iDP;
  logic [3:0]  iBLANK;
  logic [1:0]  iBRIGHT;
  logic        iLZS;
  logic        iLOAD;
  logic [3:0]  oS_COM;
  logic [7:0]  oS_ENS;
  logic        oFRAME;

  int testCount;
  int failCount;
  int cycles;
  int litCycles;

  seg7_scan_ctrl #(
    .NUM_DIGITS (4),
    .SCAN_W     (4),
    .BRIGHT_W   (2)
  ) dut (
    .iCLK    (iCLK),
    .nRST    (nRST),
    .iDATA   (iDATA),
    .iDP     (iDP),
    .iBLANK  (iBLANK),
    .iBRIGHT (iBRIGHT),
    .iLZS    (iLZS),
    .iLOAD   (iLOAD),
    .oS_COM  (oS_COM),
    .oS_ENS  (oS_ENS),
    .oFRAME  (oFRAME)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  function automatic logic [6:0] segOf(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input cfg_t c, input logic load);
    iDATA   = c.data;
    iDP     = c.dp;
    iBLANK  = c.blank;
    iBRIGHT = c.bright;
    iLZS    = c.lzs;
    iLOAD   = load;
  endtask

  // Starts one negedge after oFRAME was seen; sample j reflects slot (j-1)/16, prescaler (j-1)%16.
  task automatic runFrame(input string name, input cfg_t show, input int stopAt,
                          input int loadJ1, input cfg_t load1,
                          input int loadJ2, input cfg_t load2);
    for (int j = 1; j <= stopAt; j++) begin
      int d;
      int p;
      logic isLit;
      logic supp;
      logic [3:0] expCom;
      logic [7:0] expEns;
      @(negedge iCLK);
      d = (j - 1) / 16;
      p = (j - 1) % 16;
      isLit = !show.blank[d] && ((p >> 2) < int'(show.bright));
      supp  = show.lzs && (d != 0) && ((show.data >> (4 * d)) == 16'h0);
      expCom = 4'hF;
      expEns = 8'h00;
      if (isLit) begin
        expCom = ~(4'b0001 << d);
        expEns = {supp ? 7'b0 : segOf(show.data[4*d +: 4]), show.dp[d]};
      end
      checkOutput($sformatf("%s com j=%0d", name, j), oS_COM, expCom);
      checkOutput($sformatf("%s ens j=%0d", name, j), oS_ENS, expEns);
      checkOutput($sformatf("%s frame j=%0d", name, j), oFRAME, (j == 64));
      if (j == loadJ1)
        applyStimulus(load1, 1'b1);
      else if (j == loadJ2)
        applyStimulus(load2, 1'b1);
      else
        iLOAD = 1'b0;
    end
  endtask

  task automatic waitFrame(output int nCycles, output int nLit);
    logic seen;
    seen    = 1'b0;
    nCycles = 0;
    nLit    = 0;
    while (!seen && nCycles < 200) begin
      @(negedge iCLK);
      iLOAD = 1'b0;
      nCycles++;
      if (oS_COM != 4'hF || oS_ENS != 8'h00)
        nLit++;
      if (oFRAME)
        seen = 1'b1;
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    nRST = 1'b1;
    applyStimulus(CFG_1234, 1'b0);

    repeat (3) @(negedge iCLK);
    checkOutput("rst com", oS_COM, 4'hF);
    checkOutput("rst ens", oS_ENS, 8'h00);
    checkOutput("rst frame", oFRAME, 1'b0);

    nRST = 1'b0;
    applyStimulus(CFG_1234, 1'b1);
    waitFrame(cycles, litCycles);
    checkOutput("first frame cycle", cycles, 64);
    checkOutput("dark before load", litCycles, 0);

    runFrame("f1234", CFG_1234, 64, 30, CFG_ABCD, 63, CFG_0F00);
    runFrame("fABCD", CFG_ABCD, 64, -1, CFG_NONE, -1, CFG_NONE);
    runFrame("f0F00", CFG_0F00, 64, 10, CFG_LZ0, -1, CFG_NONE);
    runFrame("lz0000", CFG_LZ0, 64, 10, CFG_LZ100, -1, CFG_NONE);
    runFrame("lz0100", CFG_LZ100, 64, 10, CFG_BLANK0, -1, CFG_NONE);
    runFrame("blankB0", CFG_BLANK0, 64, 10, CFG_BLANK1, -1, CFG_NONE);
    runFrame("blankB1", CFG_BLANK1, 64, 10, CFG_5678, -1, CFG_NONE);
    runFrame("f5678", CFG_5678, 39, -1, CFG_NONE, -1, CFG_NONE);

    // Reset lands while slot 2 is at prescaler 7; the coincident load must be ignored.
    nRST = 1'b1;
    applyStimulus(CFG_9ABC, 1'b1);
    @(negedge iCLK);
    checkOutput("midrst com", oS_COM, 4'hF);
    checkOutput("midrst ens", oS_ENS, 8'h00);
    checkOutput("midrst frame", oFRAME, 1'b0);
    nRST = 1'b0;
    applyStimulus(CFG_9ABC, 1'b0);
    waitFrame(cycles, litCycles);
    checkOutput("post rst frame cycle", cycles, 64);
    checkOutput("post rst dark", litCycles, 0);
    runFrame("noload", CFG_NONE, 64, 5, CFG_9ABC, -1, CFG_NONE);
    runFrame("f9ABC", CFG_9ABC, 64, -1, CFG_NONE, -1, CFG_NONE);

    for (int n = 0; n < 1000 * 64; n++) begin
      cfg_t rc;
      @(negedge iCLK);
      checkOutput("one hot com", ($countones(~oS_COM) <= 1), 1'b1);
      checkOutput("dark ens", (oS_COM == 4'hF && oS_ENS != 8'h00), 1'b0);
      rc = cfg_t'($urandom);
      rc.data = 16'($urandom);
      applyStimulus(rc, ($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
